// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver: snapshots a 16-bit hex value and
// scans it onto the display with a prescaled digit rate and optional leading-zero blanking.
module seg7_scan_driver #(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter bit          COMMON_ANODE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] din,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned SEG_W   = 7;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

   // Polarity masks: XOR an active-high value with these to get the pin level.
   localparam logic [DIGITS-1:0] AN_POL  = COMMON_ANODE ? {DIGITS{1'b1}} : '0;
   localparam logic [SEG_W-1:0]  SEG_POL = COMMON_ANODE ? {SEG_W{1'b1}}  : '0;
   localparam logic              DP_POL  = COMMON_ANODE;

   logic [CNT_W-1:0]  cnt;
   logic [1:0]        idx;
   logic [15:0]       snap;
   logic [DIGITS-1:0] dps;

   logic              tick_c;
   logic [3:0]        nibble_c;
   logic [DIGITS-1:0] nz_c;
   logic              digit_on_c;
   logic [DIGITS-1:0] an_hi_c;
   logic [SEG_W-1:0]  seg_hi_c;
   logic              dp_hi_c;

   // Active-high hex decode, bit order {g,f,e,d,c,b,a}.
   function automatic logic [SEG_W-1:0] hex_decode(input logic [3:0] n);
      logic [SEG_W-1:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Current-digit selection and blanking; nz_c[k] means nibble k or any higher nibble is nonzero.
   always_comb begin
      tick_c     = (cnt == DIV_LAST);
      nibble_c   = 4'(snap >> {idx, 2'b00});
      nz_c[3]    = |snap[15:12];
      nz_c[2]    = nz_c[3] | (|snap[11:8]);
      nz_c[1]    = nz_c[2] | (|snap[7:4]);
      nz_c[0]    = 1'b1;
      digit_on_c = !blank_lz || nz_c[idx];
      an_hi_c    = '0;
      seg_hi_c   = '0;
      dp_hi_c    = 1'b0;
      if (digit_on_c) begin
         an_hi_c  = DIGITS'(1) << idx;
         seg_hi_c = hex_decode(nibble_c);
         dp_hi_c  = dps[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         snap       <= '0;
         dps        <= '0;
         frame_done <= 1'b0;
         an         <= AN_POL;
         seg        <= SEG_POL;
         dp         <= DP_POL;
      end else begin
         cnt        <= tick_c ? '0 : cnt + CNT_W'(1);
         frame_done <= tick_c && (idx == 2'd3);
         if (tick_c) begin
            idx <= idx + 2'd1;
         end
         if (load) begin
            snap <= din;
            dps  <= dp_in;
         end
         an  <= an_hi_c ^ AN_POL;
         seg <= seg_hi_c ^ SEG_POL;
         dp  <= dp_hi_c ^ DP_POL;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver at SCAN_DIV=4, common anode.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] din = '0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   seg7_scan_driver #(.SCAN_DIV(4), .COMMON_ANODE(1'b1)) dut (
      .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in),
      .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } obs_t;

   // segs = {d3,d2,d1,d0} pin levels; act = digits with an enabled; dpo = dp pin level per digit
   typedef struct packed {
      logic [15:0] din;
      logic [3:0]  dpi;
      logic        blz;
      logic [27:0] segs;
      logic [3:0]  act;
      logic [3:0]  dpo;
   } vec_t;

   localparam obs_t IDLE = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};

   vec_t vecs[8];
   obs_t sb_q[$];

   task automatic check(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got an=%b seg=%h dp=%b fd=%b, exp an=%b seg=%h dp=%b fd=%b",
                  name, $time, got.an, got.seg, got.dp, got.fd, exp.an, exp.seg, exp.dp, exp.fd);
      end
   endtask

   function automatic obs_t exp_obs(input vec_t v, input int d, input logic fd);
      obs_t o;
      o.an  = v.act[d] ? ~(4'b0001 << d) : 4'hF;
      o.seg = v.segs[d*7 +: 7];
      o.dp  = v.dpo[d];
      o.fd  = fd;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = '{an: an, seg: seg, dp: dp, fd: frame_done};
      return o;
   endfunction

   // Returns just after the posedge that raised frame_done; the next posedge shows digit0.
   task automatic wait_frame(input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (frame_done) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: frame_done not seen within 40 clks", name);
      end
   endtask

   // One full 16-clk frame starting at digit0; optional load during cycle load_at switches expectation to b.
   task automatic check_frame(input string name, input vec_t a, input vec_t b, input int load_at);
      obs_t e;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         load = (c == load_at);
         sb_q.push_back(exp_obs((load_at >= 0 && c > load_at) ? b : a, c / 4, c == 15));
         @(posedge clk); #1;
         e = sb_q.pop_front();
         check(name, sample(), e);
      end
      load = 1'b0;
   endtask

   task automatic load_vec(input vec_t v);
      @(negedge clk);
      din      = v.din;
      dp_in    = v.dpi;
      blank_lz = v.blz;
      load     = 1'b1;
      @(negedge clk);
      load     = 1'b0;
   endtask

   initial begin
      int last_fd;
      int n_fd;
      vec_t vzero;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111};
      vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0011, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'b1111};
      vecs[3] = '{16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111, 4'b1111};
      vecs[4] = '{16'h89AB, 4'b1001, 1'b1, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b1111, 4'b0110};
      vecs[5] = '{16'hCDEF, 4'b0000, 1'b0, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111, 4'b1111};
      vecs[6] = '{16'h0506, 4'b1000, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h02}, 4'b0111, 4'b1111};
      vecs[7] = '{16'hFFFF, 4'b0100, 1'b0, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1111, 4'b1011};
      vzero   = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b1111};

      // Reset holds outputs idle regardless of load/din activity.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         din   = 16'($urandom);
         dp_in = 4'($urandom);
         load  = 1'($urandom);
         @(posedge clk); #1;
         check("reset_idle", sample(), IDLE);
      end
      @(negedge clk);
      load = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;

      // First frame after release shows snap=0 and ends with frame_done on the 16th posedge.
      check_frame("post_reset", vzero, vzero, -1);

      foreach (vecs[i]) begin
         load_vec(vecs[i]);
         wait_frame("vec_wait");
         check_frame($sformatf("vec%0d", i), vecs[i], vecs[i], -1);
      end

      // Free-run: exactly 4 one-clk frame_done pulses, 16 clks apart.
      last_fd = -1;
      n_fd    = 0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         if (frame_done) begin
            n_fd++;
            if (last_fd >= 0) begin
               checks++;
               if (i - last_fd != 16) begin
                  errors++;
                  $display("FAIL fd_spacing: got %0d exp 16", i - last_fd);
               end
            end
            last_fd = i;
         end
      end
      checks++;
      if (n_fd != 4) begin
         errors++;
         $display("FAIL fd_count: got %0d exp 4", n_fd);
      end

      // Mid-frame load with no scan restart, then din changes with load=0 are ignored.
      load_vec(vecs[0]);
      wait_frame("midload_wait");
      check_frame("pre_midload", vecs[0], vecs[0], -1);
      din      = 16'hFFFF;
      dp_in    = 4'b0100;
      blank_lz = 1'b0;
      check_frame("midload", vecs[0], vecs[7], 6);
      din   = 16'h1357;
      dp_in = 4'b0011;
      check_frame("no_load", vecs[7], vecs[7], -1);

      // Reset during digit2 slot: idle immediately, then restart at digit0.
      for (int i = 0; i < 9; i++) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", sample(), IDLE);
      @(posedge clk); #1;
      check("rst_hold", sample(), IDLE);
      #1;
      rst = 1'b0;
      check_frame("rst_restart", vzero, vzero, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
